// File: rtl/versatile_mem_ctrl_ddr_pkg.sv
// rtl/versatile_mem_ctrl_ddr_pkg.sv - shared constants and helpers for the DDR data-path sequencer
package versatile_mem_ctrl_ddr_pkg;

   // Window offsets relative to the first data cycle of a burst
   localparam int WR_PRE     = 1;
   localparam int WR_POST    = 1;
   localparam int RD_CAP_DLY = 1;

   // Clock cycles per burst (two beats per clk_0 cycle)
   function automatic int burst_cycles(input int burst_len);
      return burst_len / 2;
   endfunction

   // Width of a latency field able to hold 0..max_lat
   function automatic int lat_width(input int max_lat);
      return $clog2(max_lat + 1);
   endfunction

   // Programmed latency forced into 1..max_lat
   function automatic int clamp_lat(input int lat, input int max_lat);
      if (lat < 1) begin
         return 1;
      end else if (lat > max_lat) begin
         return max_lat;
      end else begin
         return lat;
      end
   endfunction

endpackage

// File: rtl/versatile_mem_ctrl_ddr_seq_if.sv
// rtl/versatile_mem_ctrl_ddr_seq_if.sv - scheduler/FIFO/IO-flop side bundle of the DDR sequencer
interface versatile_mem_ctrl_ddr_seq_if #(
   parameter int LANES       = 2,
   parameter int DQ_PER_LANE = 8,
   parameter int MAX_LAT     = 15
);
   import versatile_mem_ctrl_ddr_pkg::*;

   localparam int DW = LANES * DQ_PER_LANE;
   localparam int LW = lat_width(MAX_LAT);

   logic [LW-1:0]      cfg_wl_i;
   logic [LW-1:0]      cfg_rl_i;
   logic               wr_cmd_i;
   logic               rd_cmd_i;
   logic [2*DW-1:0]    tx_dat_i;
   logic [2*LANES-1:0] tx_be_i;
   logic               tx_ack_o;
   logic [DW-1:0]      dq_rise_o;
   logic [DW-1:0]      dq_fall_o;
   logic [LANES-1:0]   dm_rise_o;
   logic [LANES-1:0]   dm_fall_o;
   logic               dq_oe_o;
   logic               dqs_oe_o;
   logic               dqs_gate_o;
   logic [DW-1:0]      rx_rise_i;
   logic [DW-1:0]      rx_fall_i;
   logic [2*DW-1:0]    rx_dat_o;
   logic               rx_vld_o;
   logic               busy_o;
   logic               err_o;

   modport slave (
      input  cfg_wl_i, cfg_rl_i, wr_cmd_i, rd_cmd_i, tx_dat_i, tx_be_i, rx_rise_i, rx_fall_i,
      output tx_ack_o, dq_rise_o, dq_fall_o, dm_rise_o, dm_fall_o, dq_oe_o, dqs_oe_o,
             dqs_gate_o, rx_dat_o, rx_vld_o, busy_o, err_o
   );

   modport master (
      output cfg_wl_i, cfg_rl_i, wr_cmd_i, rd_cmd_i, tx_dat_i, tx_be_i, rx_rise_i, rx_fall_i,
      input  tx_ack_o, dq_rise_o, dq_fall_o, dm_rise_o, dm_fall_o, dq_oe_o, dqs_oe_o,
             dqs_gate_o, rx_dat_o, rx_vld_o, busy_o, err_o
   );

endinterface

// File: rtl/versatile_mem_ctrl_lat_pipe.sv
// rtl/versatile_mem_ctrl_lat_pipe.sv - one-bit-per-cycle latency shift register with programmable insert tap
module versatile_mem_ctrl_lat_pipe #(
   parameter int DEPTH = 19,
   parameter int TW    = $clog2(DEPTH)
) (
   input  logic             clk_0,
   input  logic             rst_n,
   input  logic             ins,
   input  logic [TW-1:0]    tap,
   output logic [DEPTH-1:0] vec,
   output logic [DEPTH-1:0] stages
);

   // Current view: stored stages plus this cycle's command at its tap, so
   // windows that open in the command cycle itself are visible immediately
   always_comb begin
      vec = stages | (ins ? (DEPTH'(1) << tap) : '0);
   end

   // Every bit moves one position toward index 0 per cycle
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         stages <= '0;
      end else begin
         stages <= vec >> 1;
      end
   end

endmodule

// File: rtl/versatile_mem_ctrl_ddr_seq.sv
// rtl/versatile_mem_ctrl_ddr_seq.sv - DDR2 data-path sequencer: DQ/DQS/DM timing, read gating, collision detect
module versatile_mem_ctrl_ddr_seq
   import versatile_mem_ctrl_ddr_pkg::*;
#(
   parameter int LANES       = 2,
   parameter int DQ_PER_LANE = 8,
   parameter int BURST_LEN   = 4,
   parameter int MAX_LAT     = 15
) (
   input logic                           clk_0,
   input logic                           rst_n,
   versatile_mem_ctrl_ddr_seq_if.slave   bus
);

   localparam int DW    = LANES * DQ_PER_LANE;
   localparam int NB    = burst_cycles(BURST_LEN);
   localparam int HW    = NB - 1;
   // Pipe index holding a command during its first data cycle
   localparam int REF   = NB + WR_POST;
   localparam int DEPTH = MAX_LAT + NB + 2;
   localparam int TW    = $clog2(DEPTH);

   // Window decode ranges as pipe indices (higher index = earlier cycle)
   localparam int ACK_LO  = REF - NB + 1 + WR_PRE;
   localparam int ACK_HI  = REF + WR_PRE;
   localparam int OE_LO   = REF - NB + 1;
   localparam int OE_HI   = REF;
   localparam int DQS_LO  = REF - NB + 1 - WR_POST;
   localparam int DQS_HI  = REF + WR_PRE;
   localparam int GATE_LO = REF - NB + 1;
   localparam int GATE_HI = REF + RD_CAP_DLY;
   localparam int CAP_LO  = REF - NB + 1;
   localparam int CAP_HI  = REF;

   logic [DEPTH-1:0] wr_vec, wr_stg, rd_vec, rd_stg;
   logic [TW-1:0]    wr_tap, rd_tap;
   logic [HW-1:0]    wr_hist, rd_hist;
   int               wl, rl;
   logic             wr_hit, rd_hit, wr_coll, rd_coll, wr_acc, rd_acc;
   logic             tx_ack, cap;
   logic [DW-1:0]    dq_rise_q, dq_fall_q;
   logic [LANES-1:0] dm_rise_q, dm_fall_q;
   logic [2*DW-1:0]  rx_dat_q;
   logic             rx_vld_q, err_q;

   // Latency clamp, cross-direction overlap search and command acceptance
   always_comb begin
      wl     = clamp_lat(int'(bus.cfg_wl_i), MAX_LAT);
      rl     = clamp_lat(int'(bus.cfg_rl_i), MAX_LAT);
      wr_hit = 1'b0;
      rd_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         // A stored read whose gate lands inside the new write's DQS window
         if (rd_stg[i] && (i >= GATE_LO + wl - WR_PRE) && (i <= GATE_HI + wl + NB - 1 + WR_POST)) begin
            wr_hit = 1'b1;
         end
         // A stored write whose DQS drive lands inside the new read's gate
         if (wr_stg[i] && (i >= DQS_LO + rl - RD_CAP_DLY) && (i <= DQS_HI + rl + NB - 1)) begin
            rd_hit = 1'b1;
         end
      end
      wr_coll = bus.wr_cmd_i & (bus.rd_cmd_i | (|wr_hist) | wr_hit);
      rd_coll = bus.rd_cmd_i & (bus.wr_cmd_i | (|rd_hist) | rd_hit);
      wr_acc  = rst_n & bus.wr_cmd_i & ~wr_coll;
      rd_acc  = rst_n & bus.rd_cmd_i & ~rd_coll;
      wr_tap  = TW'(REF + wl);
      rd_tap  = TW'(REF + rl);
   end

   versatile_mem_ctrl_lat_pipe #(.DEPTH(DEPTH), .TW(TW)) u_wr_pipe (
      .clk_0  (clk_0),
      .rst_n  (rst_n),
      .ins    (wr_acc),
      .tap    (wr_tap),
      .vec    (wr_vec),
      .stages (wr_stg)
   );

   versatile_mem_ctrl_lat_pipe #(.DEPTH(DEPTH), .TW(TW)) u_rd_pipe (
      .clk_0  (clk_0),
      .rst_n  (rst_n),
      .ins    (rd_acc),
      .tap    (rd_tap),
      .vec    (rd_vec),
      .stages (rd_stg)
   );

   assign tx_ack = |wr_vec[ACK_HI:ACK_LO];
   assign cap    = |rd_vec[CAP_HI:CAP_LO];

   // Recent accepted commands for same-type spacing, and the sticky error
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         wr_hist <= '0;
         rd_hist <= '0;
         err_q   <= 1'b0;
      end else begin
         wr_hist <= (wr_hist << 1) | HW'(wr_acc);
         rd_hist <= (rd_hist << 1) | HW'(rd_acc);
         err_q   <= err_q | wr_coll | rd_coll;
      end
   end

   // Write data/mask follow the ack by one cycle; read words are captured under the gate
   always_ff @(posedge clk_0 or negedge rst_n) begin
      if (!rst_n) begin
         dq_rise_q <= '0;
         dq_fall_q <= '0;
         dm_rise_q <= '0;
         dm_fall_q <= '0;
         rx_dat_q  <= '0;
         rx_vld_q  <= 1'b0;
      end else begin
         dq_rise_q <= tx_ack ? bus.tx_dat_i[2*DW-1:DW] : '0;
         dq_fall_q <= tx_ack ? bus.tx_dat_i[DW-1:0] : '0;
         dm_rise_q <= tx_ack ? ~bus.tx_be_i[2*LANES-1:LANES] : '0;
         dm_fall_q <= tx_ack ? ~bus.tx_be_i[LANES-1:0] : '0;
         rx_vld_q  <= cap;
         if (cap) begin
            rx_dat_q <= {bus.rx_rise_i, bus.rx_fall_i};
         end
      end
   end

   assign bus.tx_ack_o   = tx_ack;
   assign bus.dq_rise_o  = dq_rise_q;
   assign bus.dq_fall_o  = dq_fall_q;
   assign bus.dm_rise_o  = dm_rise_q;
   assign bus.dm_fall_o  = dm_fall_q;
   assign bus.dq_oe_o    = |wr_vec[OE_HI:OE_LO];
   assign bus.dqs_oe_o   = |wr_vec[DQS_HI:DQS_LO];
   assign bus.dqs_gate_o = |rd_vec[GATE_HI:GATE_LO];
   assign bus.rx_dat_o   = rx_dat_q;
   assign bus.rx_vld_o   = rx_vld_q;
   assign bus.busy_o     = (|wr_vec) | (|rd_vec) | rx_vld_q;
   assign bus.err_o      = err_q;

endmodule

// File: tb/tb_versatile_mem_ctrl_ddr_seq.sv
// tb/tb_versatile_mem_ctrl_ddr_seq.sv - directed self-checking bench for the DDR data-path sequencer
module tb_versatile_mem_ctrl_ddr_seq;

   logic clk_0 = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk_0 = ~clk_0;

   versatile_mem_ctrl_ddr_seq_if #(.LANES(2), .DQ_PER_LANE(8), .MAX_LAT(15)) if_a ();
   versatile_mem_ctrl_ddr_seq_if #(.LANES(4), .DQ_PER_LANE(8), .MAX_LAT(15)) if_b ();

   versatile_mem_ctrl_ddr_seq #(.LANES(2), .DQ_PER_LANE(8), .BURST_LEN(4), .MAX_LAT(15)) u_dut_a (
      .clk_0 (clk_0),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   versatile_mem_ctrl_ddr_seq #(.LANES(4), .DQ_PER_LANE(8), .BURST_LEN(8), .MAX_LAT(15)) u_dut_b (
      .clk_0 (clk_0),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit in_w(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic logic [31:0] word_a(input int k);
      return {16'hA100 + 16'(k), 16'hB200 + 16'(k)};
   endfunction

   function automatic logic [63:0] word_b(input int k);
      return {32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)};
   endfunction

   task automatic run_a(input string nm, input int wr0, input int wr1, input int rd0,
                        input int wl, input int rl, input int rst_at,
                        input int ack_lo, input int ack_hi, input int oe_lo, input int oe_hi,
                        input int dqs_lo, input int dqs_hi, input int gt_lo, input int gt_hi,
                        input int vl_lo, input int vl_hi, input int err_from);
      int          fi, di, nv;
      logic [31:0] w;
      logic        live, e_vld;
      fi = 0; di = 0; nv = 0;
      rst_n = 1'b0;
      if_a.wr_cmd_i = 1'b0;
      if_a.rd_cmd_i = 1'b0;
      if_a.cfg_wl_i = 4'(wl);
      if_a.cfg_rl_i = 4'(rl);
      if_a.tx_be_i  = 4'b1101;
      @(posedge clk_0); #1;
      chk({nm, " rst ack"}, 64'(if_a.tx_ack_o), 64'd0);
      chk({nm, " rst dqs_oe"}, 64'(if_a.dqs_oe_o), 64'd0);
      chk({nm, " rst busy"}, 64'(if_a.busy_o), 64'd0);
      chk({nm, " rst err"}, 64'(if_a.err_o), 64'd0);
      chk({nm, " rst rx_dat"}, 64'(if_a.rx_dat_o), 64'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if_a.wr_cmd_i  = (c == wr0) || (c == wr1);
         if_a.rd_cmd_i  = (c == rd0);
         if_a.rx_rise_i = 16'h5000 + 16'(c);
         if_a.rx_fall_i = 16'h6000 + 16'(c);
         if_a.tx_dat_i  = word_a(fi);
         live = (rst_at < 0) || (c < rst_at);
         if (c == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk($sformatf("%s async ack@%0d", nm, c), 64'(if_a.tx_ack_o), 64'd0);
            chk($sformatf("%s async dq_oe@%0d", nm, c), 64'(if_a.dq_oe_o), 64'd0);
            chk($sformatf("%s async dqs_oe@%0d", nm, c), 64'(if_a.dqs_oe_o), 64'd0);
            chk($sformatf("%s async busy@%0d", nm, c), 64'(if_a.busy_o), 64'd0);
            chk($sformatf("%s async dq_rise@%0d", nm, c), 64'(if_a.dq_rise_o), 64'd0);
         end
         @(negedge clk_0);
         chk($sformatf("%s ack@%0d", nm, c), 64'(if_a.tx_ack_o), 64'(live && in_w(c, ack_lo, ack_hi)));
         chk($sformatf("%s dq_oe@%0d", nm, c), 64'(if_a.dq_oe_o), 64'(live && in_w(c, oe_lo, oe_hi)));
         chk($sformatf("%s dqs_oe@%0d", nm, c), 64'(if_a.dqs_oe_o), 64'(live && in_w(c, dqs_lo, dqs_hi)));
         chk($sformatf("%s gate@%0d", nm, c), 64'(if_a.dqs_gate_o), 64'(live && in_w(c, gt_lo, gt_hi)));
         if (live && in_w(c, oe_lo, oe_hi)) begin
            w = word_a(di);
            di++;
            chk($sformatf("%s dq_rise@%0d", nm, c), 64'(if_a.dq_rise_o), 64'(w[31:16]));
            chk($sformatf("%s dq_fall@%0d", nm, c), 64'(if_a.dq_fall_o), 64'(w[15:0]));
            chk($sformatf("%s dm_rise@%0d", nm, c), 64'(if_a.dm_rise_o), 64'(2'b00));
            chk($sformatf("%s dm_fall@%0d", nm, c), 64'(if_a.dm_fall_o), 64'(2'b10));
         end else begin
            chk($sformatf("%s dq_rise@%0d", nm, c), 64'(if_a.dq_rise_o), 64'd0);
            chk($sformatf("%s dq_fall@%0d", nm, c), 64'(if_a.dq_fall_o), 64'd0);
            chk($sformatf("%s dm_rise@%0d", nm, c), 64'(if_a.dm_rise_o), 64'd0);
            chk($sformatf("%s dm_fall@%0d", nm, c), 64'(if_a.dm_fall_o), 64'd0);
         end
         e_vld = live && in_w(c, vl_lo, vl_hi);
         chk($sformatf("%s rx_vld@%0d", nm, c), 64'(if_a.rx_vld_o), 64'(e_vld));
         if (e_vld) begin
            nv++;
            chk($sformatf("%s rx_dat@%0d", nm, c), 64'(if_a.rx_dat_o),
                64'({16'h5000 + 16'(c - 1), 16'h6000 + 16'(c - 1)}));
         end
         chk($sformatf("%s err@%0d", nm, c), 64'(if_a.err_o),
             64'(live && (err_from >= 0) && (c >= err_from)));
         if (live && ((c == ack_lo) || (c == gt_lo))) begin
            chk($sformatf("%s busy@%0d", nm, c), 64'(if_a.busy_o), 64'd1);
         end
         if (if_a.tx_ack_o) fi++;
         @(posedge clk_0); #1;
      end
      if_a.wr_cmd_i = 1'b0;
      if_a.rd_cmd_i = 1'b0;
      chk({nm, " busy end"}, 64'(if_a.busy_o), 64'd0);
      chk({nm, " rx words"}, 64'(nv), 64'((vl_hi >= vl_lo) ? (vl_hi - vl_lo + 1) : 0));
   endtask

   task automatic run_b();
      int          fi, di;
      logic [63:0] w;
      logic        e_oe;
      fi = 0; di = 0;
      rst_n = 1'b0;
      if_b.cfg_wl_i = 4'd0;
      if_b.cfg_rl_i = 4'd0;
      if_b.tx_be_i  = 8'h0F;
      @(posedge clk_0); #1;
      chk("b rst busy", 64'(if_b.busy_o), 64'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if_b.wr_cmd_i = (c == 10);
         if_b.tx_dat_i = word_b(fi);
         @(negedge clk_0);
         chk($sformatf("b ack@%0d", c), 64'(if_b.tx_ack_o), 64'(in_w(c, 10, 13)));
         e_oe = in_w(c, 11, 14);
         chk($sformatf("b dq_oe@%0d", c), 64'(if_b.dq_oe_o), 64'(e_oe));
         chk($sformatf("b dqs_oe@%0d", c), 64'(if_b.dqs_oe_o), 64'(in_w(c, 10, 15)));
         w = e_oe ? word_b(di) : 64'd0;
         if (e_oe) di++;
         chk($sformatf("b dq_rise@%0d", c), 64'(if_b.dq_rise_o), 64'(w[63:32]));
         chk($sformatf("b dq_fall@%0d", c), 64'(if_b.dq_fall_o), 64'(w[31:0]));
         chk($sformatf("b dm_rise@%0d", c), 64'(if_b.dm_rise_o), e_oe ? 64'hF : 64'd0);
         chk($sformatf("b dm_fall@%0d", c), 64'(if_b.dm_fall_o), 64'd0);
         chk($sformatf("b err@%0d", c), 64'(if_b.err_o), 64'd0);
         if (if_b.tx_ack_o) fi++;
         @(posedge clk_0); #1;
      end
      if_b.wr_cmd_i = 1'b0;
      chk("b data beats", 64'(di), 64'd4);
      chk("b busy end", 64'(if_b.busy_o), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      if_a.cfg_wl_i = '0; if_a.cfg_rl_i = '0; if_a.wr_cmd_i = 1'b0; if_a.rd_cmd_i = 1'b0;
      if_a.tx_dat_i = '0; if_a.tx_be_i = '0; if_a.rx_rise_i = '0; if_a.rx_fall_i = '0;
      if_b.cfg_wl_i = '0; if_b.cfg_rl_i = '0; if_b.wr_cmd_i = 1'b0; if_b.rd_cmd_i = 1'b0;
      if_b.tx_dat_i = '0; if_b.tx_be_i = '0; if_b.rx_rise_i = '0; if_b.rx_fall_i = '0;

      //     name         wr0 wr1 rd0 wl rl rst  ack     dq_oe   dqs_oe  gate    vld     err
      run_a("t1_wr",      10, -1, -1, 3, 3, -1,  12, 13, 13, 14, 12, 15, -1, -2, -1, -2, -1);
      run_a("t2_rd",      -1, -1, 20, 3, 4, -1,  -1, -2, -1, -2, -1, -2, 23, 25, 25, 26, -1);
      run_a("t3_b2b",     10, 12, -1, 3, 3, -1,  12, 15, 13, 16, 12, 17, -1, -2, -1, -2, -1);
      run_a("t4_both",     5, -1,  5, 3, 3, -1,  -1, -2, -1, -2, -1, -2, -1, -2, -1, -2,  6);
      run_a("t5_wr_rd",   10, -1, 11, 3, 3, -1,  12, 13, 13, 14, 12, 15, -1, -2, -1, -2, 12);
      run_a("t6_rst",     10, -1, -1, 3, 3, 13,  12, 12, -1, -2, 12, 12, -1, -2, -1, -2, -1);
      run_a("t6_after",   10, -1, -1, 3, 3, -1,  12, 13, 13, 14, 12, 15, -1, -2, -1, -2, -1);
      run_a("t7_close",   10, 11, -1, 3, 3, -1,  12, 13, 13, 14, 12, 15, -1, -2, -1, -2, 12);
      run_a("t8_rl_min",  -1, -1,  3, 3, 0, -1,  -1, -2, -1, -2, -1, -2,  3,  5,  5,  6, -1);
      run_b();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
